// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - cpu-side memory request/response bundle
//
// Purpose: groups the cpu memory bus between a requester (master) and
//          mem_responder (slave).
// Signals:
//   mem_addr  [31:0]  request byte address, bits [1:0] ignored
//   mem_rmask [3:0]   read byte mask, nonzero = read request
//   mem_wmask [3:0]   write byte mask, nonzero = write request
//   mem_wdata [31:0]  write data in lanes selected by mem_wmask
//   mem_rdata [31:0]  read word, zero outside the response cycle
//   mem_resp          one-cycle completion pulse
//   mem_err           error flag, pulses together with mem_resp
//   proto_err         sticky request-changed-while-pending flag
interface mem_responder_if;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        mem_err;
    logic        proto_err;

    modport master (
        output mem_addr, mem_rmask, mem_wmask, mem_wdata,
        input  mem_rdata, mem_resp, mem_err, proto_err
    );

    modport slave (
        input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
        output mem_rdata, mem_resp, mem_err, proto_err
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-port memory responder with programmable latency
//
// Purpose: serves word-aligned read/write requests from a cpu memory port.
//          A request is accepted in IDLE, held for the configured latency and
//          answered with a one-cycle mem_resp. Writes are byte-masked and
//          commit at the end of the response cycle. Out-of-range requests and
//          requests with both masks set answer with mem_err and no write.
// Parameters:
//   ADDR_WIDTH  word-address bits, depth = 2**ADDR_WIDTH words
//   BASE_ADDR   byte address of word 0 (4-byte aligned)
//   LATENCY     cycles from acceptance to mem_resp, 1..15
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   mem         mem_responder_if.slave request/response bundle
// Configuration:
//   MEM_RESPONDER_JITTER_EN  when defined, a 16-bit LFSR adds 0..3 cycles of
//                            latency per accepted request.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h1eceb000,
    parameter int unsigned LATENCY    = 2
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave mem
);

`ifdef MEM_RESPONDER_JITTER_EN
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 4;
`endif

    localparam int          DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
    // 33-bit bounds so BASE_ADDR + size never wraps at the top of the map
    localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [32:0] LIMIT_EXT = BASE_EXT + (33'd4 << ADDR_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [31:0] r_mem [DEPTH];

    logic [CNT_W-1:0] r_cnt;
    logic [29:0]      r_addr;
    logic [3:0]       r_rmask;
    logic [3:0]       r_wmask;
    logic [31:0]      r_wdata;
    logic             r_in_range;
    logic             r_err;
    logic [31:0]      r_rdata;
    logic             r_proto_err;

    logic                  w_req;
    logic                  w_accept;
    logic                  w_to_resp;
    logic [31:0]           w_aligned;
    logic                  w_live_in_range;
    logic                  w_live_err;
    logic [ADDR_WIDTH-1:0] w_live_index;
    logic [ADDR_WIDTH-1:0] w_index;
    logic [ADDR_WIDTH-1:0] w_rd_index;
    logic                  w_rd_err;
    logic                  w_mismatch;
    logic [CNT_W-1:0]      w_lat;
    logic                  w_unused;

    // Byte-offset bits are don't-care for word-aligned accesses
    assign w_unused = ^mem.mem_addr[1:0];

    assign w_aligned       = {mem.mem_addr[31:2], 2'b00};
    assign w_req           = |(mem.mem_rmask | mem.mem_wmask);
    assign w_live_in_range = ({1'b0, w_aligned} >= BASE_EXT) &&
                             ({1'b0, w_aligned} <  LIMIT_EXT);
    assign w_live_err      = !w_live_in_range ||
                             ((|mem.mem_rmask) && (|mem.mem_wmask));
    assign w_live_index    = ADDR_WIDTH'(mem.mem_addr[31:2] - BASE_WORD);
    assign w_index         = ADDR_WIDTH'(r_addr - BASE_WORD);

`ifdef MEM_RESPONDER_JITTER_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    // Fibonacci taps 16,14,13,11; the pre-advance value jitters this request
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_lat     = CNT_W'(LATENCY) + CNT_W'(r_lfsr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end
`else
    assign w_lat = CNT_W'(LATENCY);
`endif

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_accept     = 1'b1;
                    w_state_next = (w_lat == CNT_W'(1)) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_to_resp = (r_state != S_RESP) && (w_state_next == S_RESP);

    // A single-cycle request goes straight from IDLE to RESP, so the read
    // must use the live request; otherwise the latched copy is used.
    assign w_rd_index = (r_state == S_IDLE) ? w_live_index : w_index;
    assign w_rd_err   = (r_state == S_IDLE) ? w_live_err   : r_err;

    // wdata only matters while a write is pending
    assign w_mismatch = (mem.mem_addr[31:2] != r_addr)  ||
                        (mem.mem_rmask      != r_rmask) ||
                        (mem.mem_wmask      != r_wmask) ||
                        ((|r_wmask) && (mem.mem_wdata != r_wdata));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_rmask     <= '0;
            r_wmask     <= '0;
            r_wdata     <= '0;
            r_in_range  <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_addr     <= mem.mem_addr[31:2];
                r_rmask    <= mem.mem_rmask;
                r_wmask    <= mem.mem_wmask;
                r_wdata    <= mem.mem_wdata;
                r_in_range <= w_live_in_range;
                r_err      <= w_live_err;
                r_cnt      <= w_lat - CNT_W'(2);
            end else if (r_state == S_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_to_resp) begin
                r_rdata <= w_rd_err ? 32'h0 : r_mem[w_rd_index];
            end

            if ((r_state == S_WAIT || r_state == S_RESP) && w_mismatch) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // Array has no reset so contents survive rst; a write still pending
    // when rst arrives is dropped.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_RESP && r_in_range && r_rmask == 4'h0) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wmask[i]) begin
                    r_mem[w_index][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign mem.mem_resp  = (r_state == S_RESP);
    assign mem.mem_err   = (r_state == S_RESP) && r_err;
    assign mem.mem_rdata = (r_state == S_RESP) ? r_rdata : 32'h0;
    assign mem.proto_err = r_proto_err;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder (LATENCY 2 and 1)
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if m2();
    mem_responder_if m1();

    mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h1eceb000), .LATENCY(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .mem (m2)
    );

    mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h1eceb000), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .mem (m1)
    );

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        logic        chk_data;
        string       name;
    } exp_t;

    exp_t q2[$];
    exp_t q1[$];
    exp_t e2;
    exp_t e1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (m2.mem_resp) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut2_unexpected_resp: actual resp at cycle %0d required none", cyc);
                end else begin
                    e2 = q2.pop_front();
                    chk({e2.name, "_cycle"}, 32'(cyc), 32'(e2.cyc));
                    chk({e2.name, "_err"}, {31'b0, m2.mem_err}, {31'b0, e2.err});
                    if (e2.chk_data) chk({e2.name, "_rdata"}, m2.mem_rdata, e2.rdata);
                end
            end else begin
                chk("dut2_idle_rdata", m2.mem_rdata, 32'h0);
                chk("dut2_idle_err", {31'b0, m2.mem_err}, 32'h0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m1.mem_resp) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut1_unexpected_resp: actual resp at cycle %0d required none", cyc);
                end else begin
                    e1 = q1.pop_front();
                    chk({e1.name, "_cycle"}, 32'(cyc), 32'(e1.cyc));
                    chk({e1.name, "_err"}, {31'b0, m1.mem_err}, {31'b0, e1.err});
                    if (e1.chk_data) chk({e1.name, "_rdata"}, m1.mem_rdata, e1.rdata);
                end
            end
        end
    end

    task automatic idle2();
        m2.mem_addr  = 32'h0;
        m2.mem_rmask = 4'h0;
        m2.mem_wmask = 4'h0;
        m2.mem_wdata = 32'h0;
    endtask

    task automatic idle1();
        m1.mem_addr  = 32'h0;
        m1.mem_rmask = 4'h0;
        m1.mem_wmask = 4'h0;
        m1.mem_wdata = 32'h0;
    endtask

    // One request on the LATENCY=2 responder, held until the cycle after mem_resp
    task automatic req2(input string name, input logic [31:0] addr, input logic [3:0] rm,
                        input logic [3:0] wm, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input logic chk_data, input logic change_addr);
        exp_t e;
        bit   seen;
        int   n;
        @(negedge clk);
        m2.mem_addr  = addr;
        m2.mem_rmask = rm;
        m2.mem_wmask = wm;
        m2.mem_wdata = wd;
        e.cyc      = cyc + 2;
        e.rdata    = exp_rd;
        e.err      = exp_err;
        e.chk_data = chk_data;
        e.name     = name;
        q2.push_back(e);
        if (change_addr) begin
            @(negedge clk);
            m2.mem_addr = addr + 32'h4;
        end
        seen = 0;
        n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (m2.mem_resp) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: actual no resp in 20 cycles required resp", name);
        end
        @(negedge clk);
        idle2();
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        idle2();
        idle1();
        repeat (3) @(negedge clk);
        chk("reset_resp", {31'b0, m2.mem_resp}, 32'h0);
        chk("reset_err", {31'b0, m2.mem_err}, 32'h0);
        chk("reset_rdata", m2.mem_rdata, 32'h0);
        chk("reset_proto_err", {31'b0, m2.proto_err}, 32'h0);
        rst = 1'b0;

        // name, addr, rmask, wmask, wdata, exp_rdata, exp_err, chk_rdata, change_addr
        req2("wr_base",      32'h1eceb000, 4'h0, 4'hf, 32'hdeadbeef, 32'h0,        1'b0, 1'b0, 1'b0);
        req2("wr_word1",     32'h1eceb004, 4'h0, 4'hf, 32'h11223344, 32'h0,        1'b0, 1'b0, 1'b0);
        req2("wr_last",      32'h1ecebffc, 4'h0, 4'hf, 32'h5a5a5a5a, 32'h0,        1'b0, 1'b0, 1'b0);
        req2("rd_base",      32'h1eceb000, 4'hf, 4'h0, 32'h0,        32'hdeadbeef, 1'b0, 1'b1, 1'b0);
        req2("wr_byte2",     32'h1eceb006, 4'h0, 4'b0100, 32'h00aa0000, 32'h11223344, 1'b0, 1'b1, 1'b0);
        req2("rd_word1",     32'h1eceb004, 4'hf, 4'h0, 32'h0,        32'h11aa3344, 1'b0, 1'b1, 1'b0);
        req2("rd_above",     32'h1ecec000, 4'hf, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 1'b0);
        req2("wr_below",     32'h1eceafff, 4'h0, 4'hf, 32'hffffffff, 32'h0,        1'b1, 1'b1, 1'b0);
        req2("rd_last",      32'h1ecebffc, 4'hf, 4'h0, 32'h0,        32'h5a5a5a5a, 1'b0, 1'b1, 1'b0);
        req2("both_masks",   32'h1eceb000, 4'hf, 4'h1, 32'h000000ff, 32'h0,        1'b1, 1'b1, 1'b0);
        req2("rd_base2",     32'h1eceb000, 4'hf, 4'h0, 32'h0,        32'hdeadbeef, 1'b0, 1'b1, 1'b0);
        chk("proto_err_clean", {31'b0, m2.proto_err}, 32'h0);

        req2("rd_changed",   32'h1eceb000, 4'hf, 4'h0, 32'h0,        32'hdeadbeef, 1'b0, 1'b1, 1'b1);
        chk("proto_err_set", {31'b0, m2.proto_err}, 32'h1);
        req2("rd_last2",     32'h1ecebffc, 4'hf, 4'h0, 32'h0,        32'h5a5a5a5a, 1'b0, 1'b1, 1'b0);
        chk("proto_err_sticky", {31'b0, m2.proto_err}, 32'h1);

        // Reset during WAIT of a write: no response, write dropped
        @(negedge clk);
        m2.mem_addr  = 32'h1eceb004;
        m2.mem_wmask = 4'hf;
        m2.mem_wdata = 32'hffffffff;
        @(negedge clk);
        rst = 1'b1;
        idle2();
        @(negedge clk);
        chk("rst_wait_resp", {31'b0, m2.mem_resp}, 32'h0);
        chk("rst_proto_err", {31'b0, m2.proto_err}, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        req2("rd_after_rst", 32'h1eceb004, 4'hf, 4'h0, 32'h0,        32'h11aa3344, 1'b0, 1'b1, 1'b0);

        // LATENCY=1: write held continuously, responses every other cycle
        @(negedge clk);
        m1.mem_addr  = 32'h1eceb000;
        m1.mem_wmask = 4'hf;
        m1.mem_wdata = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            e.cyc      = cyc + 1 + 2 * k;
            e.rdata    = 32'h12345678;
            e.err      = 1'b0;
            e.chk_data = (k != 0);
            e.name     = $sformatf("l1_hold%0d", k);
            q1.push_back(e);
        end
        repeat (8) @(negedge clk);
        idle1();
        @(negedge clk);
        m1.mem_rmask = 4'hf;
        m1.mem_addr  = 32'h1eceb000;
        e.cyc      = cyc + 1;
        e.rdata    = 32'h12345678;
        e.err      = 1'b0;
        e.chk_data = 1'b1;
        e.name     = "l1_read";
        q1.push_back(e);
        repeat (2) @(negedge clk);
        idle1();
        chk("l1_proto_err", {31'b0, m1.proto_err}, 32'h0);

        repeat (4) @(negedge clk);
        chk("dut2_pending", 32'(q2.size()), 32'h0);
        chk("dut1_pending", 32'(q1.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual simulation still running required finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Synthesizable single-port memory responder that serves the `cpu` memory interface from the far side: it accepts word-aligned read/write requests, waits a programmable latency, and then pulses `mem_resp`. It backs `cpu` in block-level simulation and FPGA bring-up, replacing the behavioural testbench memory. Writes are byte-masked, reads always return the full word, and out-of-range or malformed requests are flagged.

## Interface
- `ADDR_WIDTH`, 10: word-address bits; array depth is 2^ADDR_WIDTH words (default 4 KiB).
- `BASE_ADDR`, 32'h1eceb000: byte address of word 0; must be 4-byte aligned.
- `LATENCY`, 2: cycles from request acceptance to `mem_resp`; legal range 1..15.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `mem_addr` in 32: request byte address; bits [1:0] are ignored.
- `mem_rmask` in 4: read byte mask; a nonzero value is a read request.
- `mem_wmask` in 4: write byte mask; a nonzero value is a write request.
- `mem_wdata` in 32: write data in byte lanes matching `mem_wmask`.
- `mem_rdata` out 32: read word; valid only while `mem_resp` is high, otherwise 0.
- `mem_resp` out 1: one-cycle completion pulse.
- `mem_err` out 1: pulses with `mem_resp` when the request was out of range or had both masks nonzero.
- `proto_err` out 1: sticky flag, set when the requester changes its request before the response; cleared only by `rst`.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: a request is present when `mem_rmask | mem_wmask` is nonzero. On acceptance the block latches addr[31:2], rmask, wmask and wdata, and computes `in_range`: `BASE_ADDR <= addr < BASE_ADDR + 4*2^ADDR_WIDTH`, using 33-bit arithmetic so the top does not wrap. Transition is to RESP if LATENCY==1, otherwise to WAIT with `cnt = LATENCY-2`.
- WAIT: `cnt` decrements each cycle. When `cnt==0`, the transition to RESP reads `array[index]` into the `mem_rdata` register, where `index = (addr - BASE_ADDR) >> 2`.
- RESP: `mem_resp=1` for exactly one cycle, then IDLE unconditionally. A request presented during the RESP cycle is not accepted; acceptance happens no earlier than the following IDLE cycle.
- Write commit: at the clock edge ending RESP, each lane i with `wmask[i]` set is written (`array[index][8i+:8] <= wdata[8i+:8]`). The write happens only if `in_range` and `rmask==0`.
- Error request (out of range, or both masks nonzero): the response still occurs after the normal latency, with `mem_rdata=0`, `mem_err=1` and no write.
- Protocol check: in WAIT or RESP, if the live `mem_addr[31:2]`, `mem_rmask`, `mem_wmask` or `mem_wdata` (writes only) differs from the latched copy, `proto_err` is set. The response always uses the latched copy.
- Reset: state goes to IDLE and `mem_resp`, `mem_err`, `mem_rdata` and `proto_err` go to 0. A pending write is discarded. Array contents are retained, never cleared.

## Timing
- Request first visible in IDLE at cycle T: `mem_resp` is high in cycle T+LATENCY; the write is visible to a read accepted at T+LATENCY+1 or later.
- Minimum occupancy per request is LATENCY+1 cycles, including the IDLE acceptance cycle.
- `rst` asserted during WAIT at cycle T: no `mem_resp` is produced for that request, and the block is IDLE at T+1.
- Reset values: `mem_rdata=0`, `mem_resp=0`, `mem_err=0`, `proto_err=0`.

## Configuration
- `MEM_RESPONDER_JITTER_EN` defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset value 16'hACE1) advances once per accepted request. Its bits [1:0] are added to the latency of that request, so per-request latency is LATENCY+0..3. `cnt` widens to 5 bits.
- Not defined: latency is fixed at LATENCY and no LFSR exists.

## Test plan
- Read latency, LATENCY=2: preload word at 0x1eceb000 with 0xdeadbeef; hold `mem_addr=0x1eceb000`, `rmask=4'hf` from T -> `mem_resp`=1 only at T+2, with `mem_rdata=0xdeadbeef`, `mem_err=0`.
- Byte-masked write: word at 0x1eceb004 holds 0x11223344; write `mem_addr=0x1eceb006`, `wmask=4'b0100`, `wdata=0x00aa0000`; then read 0x1eceb004 -> 0x11aa3344.
- Out of range: read at 0x1eceb000+0x1000 (ADDR_WIDTH=10) -> `mem_resp` and `mem_err` pulse together with `mem_rdata=0`; write to 0x1eceafff -> `mem_err`=1 and the array is unchanged.
- Both masks nonzero: `rmask=4'hf`, `wmask=4'h1` -> `mem_err`=1 and no write.
- Mid-request change and reset: change `mem_addr` during WAIT -> `proto_err` sticks at 1 and the latched address is served. Then assert `rst` during WAIT of a write -> no `mem_resp`, `proto_err`=0 and the target word is unchanged.
- LATENCY=1 back-to-back: request held continuously -> `mem_resp` on alternating cycles (T+1, T+3, ...), never on two consecutive cycles.
